// File: rtl/core_psr_file_if.sv
// core_psr_file_if: PSR write strobes, ALU flag writeback and PSR read-back
// between the PSR control stage (master) and the PSR storage (slave).
interface core_psr_file_if;
  // write side, driven by the PSR control stage / ALU writeback
  logic        psr_write;
  logic        psr_saved;
  logic        psr_wr_flags;
  logic        psr_wr_control;
  logic [31:0] psr_wr;
  logic        update_flags;
  logic [3:0]  alu_nzcv;
  logic        alu_q;
  // read side, driven by the PSR file
  logic [31:0] cpsr_rd;
  logic [31:0] spsr_rd;
  logic [4:0]  mode;
  logic        irq_mask;
  logic        fiq_mask;
  logic        bad_mode;

  modport master (
    output psr_write, psr_saved, psr_wr_flags, psr_wr_control, psr_wr,
           update_flags, alu_nzcv, alu_q,
    input  cpsr_rd, spsr_rd, mode, irq_mask, fiq_mask, bad_mode
  );

  modport slave (
    input  psr_write, psr_saved, psr_wr_flags, psr_wr_control, psr_wr,
           update_flags, alu_nzcv, alu_q,
    output cpsr_rd, spsr_rd, mode, irq_mask, fiq_mask, bad_mode
  );
endinterface

// File: rtl/core_psr_file.sv
// core_psr_file: CPSR plus banked SPSRs (FIQ/IRQ/SVC/ABT/UND).
// Writes land on the next clock edge, reads are straight from the registers.
// Optional feature macro: PSR_Q_BIT_EN -- sticky Q flag in CPSR[27] / SPSR[27].
module core_psr_file #(
  parameter logic [31:0] RST_CPSR = 32'h000000D3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  core_psr_file_if.slave        psr_if
);

  localparam logic [4:0] MODE_USR = 5'b10000;
  localparam logic [4:0] MODE_FIQ = 5'b10001;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_ABT = 5'b10111;
  localparam logic [4:0] MODE_UND = 5'b11011;
  localparam logic [4:0] MODE_SYS = 5'b11111;

  localparam int NBANK = 5;

`ifdef PSR_Q_BIT_EN
  // Q is a real, sticky bit in both CPSR and SPSR
  localparam logic [7:0] FLAG_MASK = 8'hFF;
  logic w_q_set;
  assign w_q_set = psr_if.update_flags & psr_if.alu_q;
`else
  // no saturation support: bit 27 never stores anything
  localparam logic [7:0] FLAG_MASK = 8'hF7;
  logic w_q_set;
  assign w_q_set = 1'b0;
`endif

  // CPSR split into its live fields; [23:8] and T are constant 0
  logic [7:0]             r_flags;
  logic [1:0]             r_ifm;
  logic [4:0]             r_mode;
  logic                   r_bad_mode;

  // SPSR banks keep only the fields that can ever be non-zero
  logic [NBANK-1:0][7:0]  r_spsr_hi;
  logic [NBANK-1:0][7:0]  r_spsr_lo;

  logic                   w_cpsr_wr;
  logic                   w_spsr_wr;
  logic                   w_ctrl_en;
  logic                   w_mode_ok;
  logic [NBANK-1:0]       w_bank_oh;
  logic [NBANK-1:0]       w_spsr_we;
  logic [7:0]             w_flags_nxt;
  logic [1:0]             w_ifm_nxt;
  logic [4:0]             w_mode_nxt;
  logic                   w_bad_nxt;
  logic [31:0]            w_spsr_rd;
  logic                   w_unused_bits;

  // legal mode encodings; anything else is rejected on CPSR writes
  function automatic logic mode_valid(input logic [4:0] m);
    case (m)
      MODE_USR, MODE_FIQ, MODE_IRQ, MODE_SVC,
      MODE_ABT, MODE_UND, MODE_SYS: mode_valid = 1'b1;
      default:                      mode_valid = 1'b0;
    endcase
  endfunction

  // one-hot SPSR bank for a mode; USR/SYS (and anything else) have none
  function automatic logic [NBANK-1:0] mode_bank(input logic [4:0] m);
    case (m)
      MODE_FIQ: mode_bank = 5'b00001;
      MODE_IRQ: mode_bank = 5'b00010;
      MODE_SVC: mode_bank = 5'b00100;
      MODE_ABT: mode_bank = 5'b01000;
      MODE_UND: mode_bank = 5'b10000;
      default:  mode_bank = '0;
    endcase
  endfunction

  assign w_cpsr_wr = psr_if.psr_write & ~psr_if.psr_saved;
  assign w_spsr_wr = psr_if.psr_write &  psr_if.psr_saved;

  // bank select uses the pre-write mode, so an exception entry's second
  // write naturally hits the SPSR of the mode the first write switched to
  assign w_bank_oh = mode_bank(r_mode);
  assign w_spsr_we = w_bank_oh & {NBANK{w_spsr_wr}};

  // control field is privileged: a USR-mode control write is dropped silently
  assign w_ctrl_en = w_cpsr_wr & psr_if.psr_wr_control & (r_mode != MODE_USR);
  assign w_mode_ok = mode_valid(psr_if.psr_wr[4:0]);

  // bits that are architecturally dropped (and alu_q when Q is compiled out)
  assign w_unused_bits = ^{psr_if.psr_wr[23:8], psr_if.alu_q};

  // flag byte: ALU NZCV first, then an explicit PSR flags write overrides it
  always_comb begin
    w_flags_nxt = r_flags;
    if (psr_if.update_flags) begin
      w_flags_nxt[7:4] = psr_if.alu_nzcv;
      if (w_q_set) w_flags_nxt[3] = 1'b1;
    end
    if (w_cpsr_wr && psr_if.psr_wr_flags) w_flags_nxt = psr_if.psr_wr[31:24];
    w_flags_nxt = w_flags_nxt & FLAG_MASK;
  end

  // control byte: I/F always follow the write, mode only if it is legal
  always_comb begin
    w_ifm_nxt  = r_ifm;
    w_mode_nxt = r_mode;
    w_bad_nxt  = 1'b0;
    if (w_ctrl_en) begin
      w_ifm_nxt = psr_if.psr_wr[7:6];
      if (w_mode_ok) w_mode_nxt = psr_if.psr_wr[4:0];
      else           w_bad_nxt  = 1'b1;
    end
  end

  // CPSR state and the one-cycle bad-mode flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags    <= RST_CPSR[31:24] & FLAG_MASK;
      r_ifm      <= RST_CPSR[7:6];
      r_mode     <= RST_CPSR[4:0];
      r_bad_mode <= 1'b0;
    end else begin
      r_flags    <= w_flags_nxt;
      r_ifm      <= w_ifm_nxt;
      r_mode     <= w_mode_nxt;
      r_bad_mode <= w_bad_nxt;
    end
  end

  // SPSR banks: masked field writes into the bank of the current mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spsr_hi <= '0;
      r_spsr_lo <= '0;
    end else begin
      for (int b = 0; b < NBANK; b++) begin
        if (w_spsr_we[b]) begin
          if (psr_if.psr_wr_flags)   r_spsr_hi[b] <= psr_if.psr_wr[31:24] & FLAG_MASK;
          if (psr_if.psr_wr_control) r_spsr_lo[b] <= psr_if.psr_wr[7:0];
        end
      end
    end
  end

  // SPSR read mux; no bank selected reads as zero
  always_comb begin
    w_spsr_rd = '0;
    for (int b = 0; b < NBANK; b++)
      if (w_bank_oh[b]) w_spsr_rd = {r_spsr_hi[b], 16'h0000, r_spsr_lo[b]};
  end

  assign psr_if.cpsr_rd  = {r_flags, 16'h0000, r_ifm, 1'b0, r_mode};
  assign psr_if.spsr_rd  = w_spsr_rd;
  assign psr_if.mode     = r_mode;
  assign psr_if.irq_mask = r_ifm[1];
  assign psr_if.fiq_mask = r_ifm[0];
  assign psr_if.bad_mode = r_bad_mode;

endmodule

// File: tb/tb_core_psr_file.sv
// tb_core_psr_file: directed vectors for core_psr_file with hand-computed results.
module tb_core_psr_file;

`ifdef PSR_Q_BIT_EN
  localparam bit Q_EN = 1'b1;
`else
  localparam bit Q_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  core_psr_file_if psr_if ();

  core_psr_file #(.RST_CPSR(32'h000000D3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .psr_if (psr_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    psr_if.psr_write      = 1'b0;
    psr_if.psr_saved      = 1'b0;
    psr_if.psr_wr_flags   = 1'b0;
    psr_if.psr_wr_control = 1'b0;
    psr_if.psr_wr         = 32'h0;
    psr_if.update_flags   = 1'b0;
    psr_if.alu_nzcv       = 4'h0;
    psr_if.alu_q          = 1'b0;
  endtask

  // one clock of stimulus: drive at negedge, edge, then settle 1 time unit
  task automatic cyc(input logic wr, input logic saved, input logic f, input logic c,
                     input logic [31:0] d, input logic upd, input logic [3:0] nzcv,
                     input logic q);
    @(negedge clk);
    psr_if.psr_write      = wr;
    psr_if.psr_saved      = saved;
    psr_if.psr_wr_flags   = f;
    psr_if.psr_wr_control = c;
    psr_if.psr_wr         = d;
    psr_if.update_flags   = upd;
    psr_if.alu_nzcv       = nzcv;
    psr_if.alu_q          = q;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic cpsr_wr(input logic f, input logic c, input logic [31:0] d);
    cyc(1'b1, 1'b0, f, c, d, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic spsr_wr(input logic f, input logic c, input logic [31:0] d);
    cyc(1'b1, 1'b1, f, c, d, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0);
  endtask

  logic [7:0] bank_modes [5];
  logic [31:0] q_bit;

  initial begin
    n_chk = 0;
    n_err = 0;
    idle_inputs();
    bank_modes[0] = 8'hD1; bank_modes[1] = 8'hD2; bank_modes[2] = 8'hD3;
    bank_modes[3] = 8'hD7; bank_modes[4] = 8'hDB;
    q_bit = Q_EN ? 32'h08000000 : 32'h0;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // reset state
    chk("rst_cpsr", psr_if.cpsr_rd, 32'h000000D3);
    chk("rst_mode", {27'd0, psr_if.mode}, 32'h13);
    chk("rst_spsr", psr_if.spsr_rd, 32'h0);
    chk("rst_irq",  {31'd0, psr_if.irq_mask}, 32'h1);
    chk("rst_fiq",  {31'd0, psr_if.fiq_mask}, 32'h1);
    chk("rst_bad",  {31'd0, psr_if.bad_mode}, 32'h0);

    // write not visible before the edge
    @(negedge clk);
    psr_if.psr_write = 1'b1; psr_if.psr_wr_flags = 1'b1; psr_if.psr_wr_control = 1'b1;
    psr_if.psr_wr = 32'hF0000012;
    #1;
    chk("no_bypass", psr_if.cpsr_rd, 32'h000000D3);
    @(posedge clk);
    #1;
    idle_inputs();
    chk("svc2irq_cpsr", psr_if.cpsr_rd, 32'hF0000012);
    chk("svc2irq_mode", {27'd0, psr_if.mode}, 32'h12);
    chk("svc2irq_irq",  {31'd0, psr_if.irq_mask}, 32'h0);

    // exception-entry second write lands in IRQ SPSR
    spsr_wr(1'b1, 1'b1, 32'h600000D3);
    chk("irq_spsr", psr_if.spsr_rd, 32'h600000D3);
    chk("irq_cpsr_kept", psr_if.cpsr_rd, 32'hF0000012);
    cpsr_wr(1'b0, 1'b1, 32'h00000013);
    chk("svc_cpsr", psr_if.cpsr_rd, 32'hF0000013);
    chk("svc_spsr_zero", psr_if.spsr_rd, 32'h0);
    cpsr_wr(1'b0, 1'b1, 32'h000000D2);
    chk("irq_spsr_kept", psr_if.spsr_rd, 32'h600000D3);

    // SPSR field masking: [23:8] dropped, bit 27 only with Q
    cpsr_wr(1'b0, 1'b1, 32'h000000D3);
    spsr_wr(1'b1, 1'b1, 32'hFFFFFFFF);
    chk("svc_spsr_mask", psr_if.spsr_rd, Q_EN ? 32'hFF0000FF : 32'hF70000FF);

    // invalid mode: mode kept, I/F written, one-cycle bad_mode
    cpsr_wr(1'b0, 1'b1, 32'h00000014);
    chk("bad_cpsr", psr_if.cpsr_rd, 32'hF0000013);
    chk("bad_pulse", {31'd0, psr_if.bad_mode}, 32'h1);
    idle_cyc();
    chk("bad_clear", {31'd0, psr_if.bad_mode}, 32'h0);

    // ALU flags alone, then against a PSR flags write
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 4'b0110, 1'b0);
    chk("nzcv_alone", psr_if.cpsr_rd, 32'h60000013);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h90000000, 1'b1, 4'b0110, 1'b0);
    chk("psr_wins", psr_if.cpsr_rd, 32'h90000013);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h000000D3, 1'b1, 4'b1010, 1'b0);
    chk("nzcv_plus_ctrl", psr_if.cpsr_rd, 32'hA00000D3);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h00000011, 1'b1, 4'b0001, 1'b0);
    chk("nzcv_w_spsr_c", psr_if.cpsr_rd, 32'h100000D3);
    chk("nzcv_w_spsr_s", psr_if.spsr_rd, Q_EN ? 32'hFF000011 : 32'hF7000011);

    // USR: control writes ignored, flags still writable, no SPSR
    cpsr_wr(1'b1, 1'b1, 32'h00000010);
    chk("usr_cpsr", psr_if.cpsr_rd, 32'h00000010);
    chk("usr_spsr", psr_if.spsr_rd, 32'h0);
    cpsr_wr(1'b0, 1'b1, 32'h000000D3);
    chk("usr_ctrl_ign", psr_if.cpsr_rd, 32'h00000010);
    chk("usr_no_bad", {31'd0, psr_if.bad_mode}, 32'h0);
    cpsr_wr(1'b1, 1'b0, 32'h80000000);
    chk("usr_flags", psr_if.cpsr_rd, 32'h80000010);

    // asynchronous reset mid-sequence
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", psr_if.cpsr_rd, 32'h000000D3);
    @(negedge clk);
    rst_n = 1'b1;

    // SYS: SPSR write dropped, every bank still clear
    cpsr_wr(1'b1, 1'b1, 32'h0000001F);
    chk("sys_cpsr", psr_if.cpsr_rd, 32'h0000001F);
    spsr_wr(1'b1, 1'b1, 32'hFFFFFFFF);
    chk("sys_spsr", psr_if.spsr_rd, 32'h0);
    for (int b = 0; b < 5; b++) begin
      cpsr_wr(1'b0, 1'b1, {24'h0, bank_modes[b]});
      chk($sformatf("bank%0d_mode", b), psr_if.cpsr_rd, {24'h0, bank_modes[b]});
      chk($sformatf("bank%0d_zero", b), psr_if.spsr_rd, 32'h0);
    end

    // Q: sticky with Q support, otherwise always 0
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 4'b0000, 1'b1);
    chk("q_set", psr_if.cpsr_rd, 32'h000000DB | q_bit);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 4'b1000, 1'b0);
    chk("q_sticky", psr_if.cpsr_rd, 32'h800000DB | q_bit);
    cpsr_wr(1'b1, 1'b0, 32'h00000000);
    chk("q_clear", psr_if.cpsr_rd, 32'h000000DB);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  // hard stop in case stimulus ever stalls
  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
